// File: rtl/sw_input_port_pkg.sv
// Shared constants for the switch/button entry port: FSM encoding, nibble width
// and the default debounce length.
package sw_input_port_pkg;

  localparam int NIBBLE_W           = 4;
  localparam int DEB_CYCLES_DEFAULT = 16;

  localparam logic [1:0] ST_ENTRY   = 2'd0;
  localparam logic [1:0] ST_FULL    = 2'd1;
  localparam logic [1:0] ST_DELIVER = 2'd2;

endpackage

// File: rtl/sw_input_port_btn_debounce.sv
// Counter-based button debouncer: a raw level must differ from the accepted level
// for DEB_CYCLES consecutive cycles before it is taken; rise pulses on 0->1 acceptance.
module btn_debounce
  import sw_input_port_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      rise   <= 1'b0;
      cnt    <= '0;
    end else begin
      rise <= 1'b0;
      if (raw == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= raw;
        rise   <= raw;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sw_input_port.sv
// Debounced hex-nibble entry port delivering a DATA_W word to the CPU on request.
// Optional macro SW_INPUT_SYNC_EN adds 2-flop synchronizers on the raw inputs.
module sw_input_port
  import sw_input_port_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [NIBBLE_W-1:0]                         sw_nibble,
  input  logic                                        btn_push_raw,
  input  logic                                        btn_clear_raw,
  input  logic                                        rd_req,
  output logic                                        rd_ack,
  output logic [DATA_W-1:0]                           rd_data,
  output logic                                        stall,
  output logic [DATA_W-1:0]                           entry_val,
  output logic [$clog2(DATA_W/NIBBLE_W+1)-1:0]        entry_cnt,
  output logic                                        full,
  output logic [1:0]                                  fsm_state
);

  localparam int NIBBLES = DATA_W / NIBBLE_W;
  localparam int CNT_W   = $clog2(NIBBLES + 1);

  logic                push_s;
  logic                clear_s;
  logic [NIBBLE_W-1:0] nib_s;

`ifdef SW_INPUT_SYNC_EN
  logic [1:0]          push_sync;
  logic [1:0]          clear_sync;
  logic [NIBBLE_W-1:0] nib_sync0;
  logic [NIBBLE_W-1:0] nib_sync1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_sync  <= '0;
      clear_sync <= '0;
      nib_sync0  <= '0;
      nib_sync1  <= '0;
    end else begin
      push_sync  <= {push_sync[0], btn_push_raw};
      clear_sync <= {clear_sync[0], btn_clear_raw};
      nib_sync0  <= sw_nibble;
      nib_sync1  <= nib_sync0;
    end
  end

  assign push_s  = push_sync[1];
  assign clear_s = clear_sync[1];
  assign nib_s   = nib_sync1;
`else
  assign push_s  = btn_push_raw;
  assign clear_s = btn_clear_raw;
  assign nib_s   = sw_nibble;
`endif

  logic push_stable;
  logic clear_stable;
  logic push_ev;
  logic clear_ev;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_push_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (push_s),
    .stable (push_stable),
    .rise   (push_ev)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clear_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (clear_s),
    .stable (clear_stable),
    .rise   (clear_ev)
  );

  // Read handshake: rd_req is a level held by the CPU until it sees rd_ack; rd_ack
  // is a single-cycle pulse with rd_data valid in that cycle. A request dropped
  // before rd_ack cancels cleanly, and stall only ever reflects the live rd_req.
  logic [1:0] state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ENTRY;
      entry_val <= '0;
      entry_cnt <= '0;
      full      <= 1'b0;
      rd_ack    <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_ack <= 1'b0;
      case (state)
        ST_ENTRY: begin
          if (clear_ev) begin
            entry_val <= '0;
            entry_cnt <= '0;
          end else if (push_ev) begin
            entry_val <= {entry_val[DATA_W-NIBBLE_W-1:0], nib_s};
            entry_cnt <= entry_cnt + CNT_W'(1);
            if (entry_cnt == CNT_W'(NIBBLES - 1)) begin
              state <= ST_FULL;
              full  <= 1'b1;
            end
          end
        end
        ST_FULL: begin
          // A pending read beats a same-cycle clear so the finished word is not lost.
          if (rd_req) begin
            state   <= ST_DELIVER;
            rd_ack  <= 1'b1;
            rd_data <= entry_val;
          end else if (clear_ev) begin
            state     <= ST_ENTRY;
            entry_val <= '0;
            entry_cnt <= '0;
            full      <= 1'b0;
          end
        end
        ST_DELIVER: begin
          state     <= ST_ENTRY;
          entry_val <= '0;
          entry_cnt <= '0;
          full      <= 1'b0;
        end
        default: begin
          state <= ST_ENTRY;
        end
      endcase
    end
  end

  assign stall     = rd_req & ~((state == ST_FULL) | (state == ST_DELIVER));
  assign fsm_state = state;

endmodule
